fetch_decode_stage: RTL and testbench
=====================================

Name: fetch_decode_stage

Overview:
- Instruction fetch plus IF/ID pipeline register, directly upstream of Control_Unit_Top.
- Holds the PC and runs a req/ack handshake with instruction memory.
- Buffers one instruction under downstream stall; handles branch redirect.
- Presents registered decoded fields (tipo, op, inm, rd, rn, rm, imm) and id_pc to the control unit and register file.

Parameters:
PC_W, 32, PC and imem_addr width
INSTR_W, 32, instruction width
IMM_W, 19, raw immediate width taken from instr[IMM_W-1:0] (extension done downstream via ImmSrc)
RESET_PC, 32'h0000_0000, PC after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address
imem_rdata  in  INSTR_W  instruction, valid when imem_ack=1
imem_ack  in  1  single-cycle completion pulse
br_taken  in  1  redirect request from execute
br_target  in  PC_W  redirect address
id_ready  in  1  downstream accepts the current instruction this cycle
id_valid  out  1  IF/ID register holds a valid instruction
tipo  out  2  instr[31:30]
op  out  2  instr[29:28]
inm  out  1  instr[27]
rd  out  4  instr[26:23]
rn  out  4  instr[22:19]
rm  out  4  instr[18:15]
imm  out  IMM_W  instr[IMM_W-1:0]
id_pc  out  PC_W  address of the instruction in IF/ID

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=IDLE.
  - id_valid=0, imem_req=0, imem_addr=RESET_PC.
  - All field outputs and id_pc=0; pending buffer empty.
- Memory contract:
  - imem_addr is stable while imem_req=1 until the ack.
  - Ack is accepted only while imem_req=1; rdata is sampled on the ack cycle.
- Transfer out: an instruction is consumed on a cycle with id_valid=1 and id_ready=1.
- All outputs are registered. Fetch-to-id_valid latency is 1 cycle after the ack.
- FSM:
  - IDLE: req=0. Next cycle go to FETCH.
  - FETCH: req=1, addr=pc. On ack, with the slot free (id_valid=0 or consumed this cycle):
    - load IF/ID with rdata and id_pc=pc; id_valid=1; pc=pc+4; stay in FETCH.
  - FETCH: on ack with the slot occupied and not consumed:
    - store rdata/pc into the pending buffer; pc=pc+4; go to HOLD.
  - HOLD: req=0.
    - On consume: move pending into IF/ID (id_valid stays 1) and go to FETCH.
  - DRAIN: req=1, addr=old pc, held stable.
    - On ack: discard data, pc=saved target, go to FETCH.
- Redirect (br_taken=1), highest priority:
  - id_valid=0 and pending discarded in every state.
  - FETCH, no ack this cycle: save the target and go to DRAIN.
  - FETCH, ack same cycle: discard the data, pc=target, stay in FETCH.
  - HOLD or IDLE: pc=target, go to FETCH.
  - DRAIN: overwrite the saved target (latest redirect wins).
- Stall with id_valid=1 and id_ready=0: all IF/ID outputs are held unchanged.
- PC arithmetic is modulo 2^PC_W: 0xFFFF_FFFC + 4 wraps to 0.
- Reset mid-transaction: req drops immediately. The memory is required to abandon the outstanding access.

Optional Feature:
HALT_DECODE_EN
- Defined: an instruction with tipo=2'b11 loaded into IF/ID enters state HALTED.
  - HALTED: req=0, pc frozen. The halt instruction is presented with id_valid=1 until consumed, then id_valid=0.
  - Exit only by reset or br_taken (pc=target, go to FETCH).
  - Extra output halted (1 bit, 1 in HALTED) is present.
- Undefined: tipo=2'b11 is passed through like any other instruction; no HALTED state and no halted port.

Test Plan:
1. Reset release, memory acks every cycle, id_ready=1 → imem_addr sequence 0,4,8,C; id_pc follows one cycle later. Word 0x4A80_0005 → tipo=01, op=00, inm=1, rd=5, imm=5.
2. id_ready=0 held 3 cycles after the first instruction → second ack goes to the pending buffer, FSM in HOLD, req=0, outputs stable. id_ready=1 → second instruction appears next cycle, req resumes at addr 8.
3. br_taken=1, br_target=0x100 while FETCH waits for a 3-cycle ack → DRAIN with addr held. Stale data dropped, id_valid=0, next req addr=0x100.
4. br_taken and ack in the same cycle, target 0x40 → no instruction issued, next addr=0x40.
5. pc=0xFFFF_FFFC fetched → next addr=0x0000_0000. rst_n pulsed low mid-wait → req=0, id_valid=0 asynchronously, restart at RESET_PC.
6. (HALT_DECODE_EN) fetch 0xC000_0000 → halted=1, req stays 0 for 10 cycles. br_taken to 0x20 → fetch resumes at 0x20.

Source files
------------

// File: rtl/fetch_decode_stage.sv
`default_nettype none
// ============================================================================
// fetch_decode_stage : PC/imem fetch with req-ack, IF/ID register, 1-deep stall
// buffer and branch redirect. Optional macro HALT_DECODE_EN. Rev 1.0
// ============================================================================
module fetch_decode_stage #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter int              IMM_W    = 19,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [1:0]         tipo,
  output logic [1:0]         op,
  output logic               inm,
  output logic [3:0]         rd,
  output logic [3:0]         rn,
  output logic [3:0]         rm,
  output logic [IMM_W-1:0]   imm,
`ifdef HALT_DECODE_EN
  output logic               halted,
`endif
  output logic [PC_W-1:0]    id_pc
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_HOLD   = 3'd2,
    S_DRAIN  = 3'd3
`ifdef HALT_DECODE_EN
    , S_HALTED = 3'd4
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    tgt_q, tgt_d;
  logic [PC_W-1:0]    id_pc_q, id_pc_d;
  logic [PC_W-1:0]    pend_pc_q, pend_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] pend_instr_q, pend_instr_d;
  logic               id_valid_q, id_valid_d;
  logic               req_q, req_d;
  logic               ack_v;
  logic               consume;
`ifdef HALT_DECODE_EN
  logic               halted_q;
`endif

  assign ack_v   = imem_ack & req_q;
  assign consume = id_valid_q & id_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    id_pc_d      = id_pc_q;
    instr_d      = instr_q;
    pend_pc_d    = pend_pc_q;
    pend_instr_d = pend_instr_q;
    id_valid_d   = id_valid_q & ~consume;

    if (br_taken) begin
      // A redirect flushes IF/ID and the pending slot; an unacked fetch must still drain.
      id_valid_d = 1'b0;
      case (state_q)
        S_FETCH: begin
          if (ack_v) begin
            pc_d = br_target;
          end else begin
            tgt_d   = br_target;
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (ack_v) begin
            pc_d    = br_target;
            state_d = S_FETCH;
          end else begin
            tgt_d = br_target;
          end
        end
        default: begin
          pc_d    = br_target;
          state_d = S_FETCH;
        end
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (ack_v) begin
            pc_d = pc_q + PC_W'(4);
            if (!id_valid_q || consume) begin
              instr_d    = imem_rdata;
              id_pc_d    = pc_q;
              id_valid_d = 1'b1;
`ifdef HALT_DECODE_EN
              if (imem_rdata[31:30] == 2'b11) state_d = S_HALTED;
`endif
            end else begin
              pend_instr_d = imem_rdata;
              pend_pc_d    = pc_q;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (consume) begin
            instr_d    = pend_instr_q;
            id_pc_d    = pend_pc_q;
            id_valid_d = 1'b1;
            state_d    = S_FETCH;
`ifdef HALT_DECODE_EN
            if (pend_instr_q[31:30] == 2'b11) state_d = S_HALTED;
`endif
          end
        end
        S_DRAIN: begin
          if (ack_v) begin
            pc_d    = tgt_q;
            state_d = S_FETCH;
          end
        end
        default: ;
      endcase
    end

    req_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      tgt_q        <= '0;
      id_pc_q      <= '0;
      pend_pc_q    <= '0;
      instr_q      <= '0;
      pend_instr_q <= '0;
      id_valid_q   <= 1'b0;
      req_q        <= 1'b0;
`ifdef HALT_DECODE_EN
      halted_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      id_pc_q      <= id_pc_d;
      pend_pc_q    <= pend_pc_d;
      instr_q      <= instr_d;
      pend_instr_q <= pend_instr_d;
      id_valid_q   <= id_valid_d;
      req_q        <= req_d;
`ifdef HALT_DECODE_EN
      halted_q     <= (state_d == S_HALTED);
`endif
    end
  end

  // pc_q only moves on an ack or a redirect, so it doubles as the stable fetch address.
  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign tipo      = instr_q[31:30];
  assign op        = instr_q[29:28];
  assign inm       = instr_q[27];
  assign rd        = instr_q[26:23];
  assign rn        = instr_q[22:19];
  assign rm        = instr_q[18:15];
  assign imm       = instr_q[IMM_W-1:0];
`ifdef HALT_DECODE_EN
  assign halted    = halted_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_decode_stage : randomized scoreboard bench for fetch_decode_stage.
// Rev 1.0
// ============================================================================
module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        br_taken;
  logic [31:0] br_target;
  logic        id_ready;
  logic        id_valid;
  logic [1:0]  tipo;
  logic [1:0]  op;
  logic        inm;
  logic [3:0]  rd;
  logic [3:0]  rn;
  logic [3:0]  rm;
  logic [18:0] imm;
  logic [31:0] id_pc;
`ifdef HALT_DECODE_EN
  logic        halted;
`endif

  fetch_decode_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .id_ready   (id_ready),
    .id_valid   (id_valid),
    .tipo       (tipo),
    .op         (op),
    .inm        (inm),
    .rd         (rd),
    .rn         (rn),
    .rm         (rm),
    .imm        (imm),
`ifdef HALT_DECODE_EN
    .halted     (halted),
`endif
    .id_pc      (id_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  int   total    = 0;
  int   bad      = 0;
  int   n_cons   = 0;
  int   mem_mode = 0;   // 0: ack every cycle, 1: random latency, 2: fixed latency
  int   mem_lat  = 2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Program image: fixed words at 0 and 0x200, elsewhere an address hash with tipo != 2'b11.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (a == 32'h0)   return 32'h4A80_0005;
    if (a == 32'h200) return 32'hC000_0000;
    w = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    if (w[31:30] == 2'b11) w[31] = 1'b0;
    return w;
  endfunction

  function automatic int pick_lat();
    if (mem_mode == 0) return 0;
    if (mem_mode == 1) return int'($urandom_range(0, 3));
    return mem_lat;
  endfunction

  // Expected instruction stream from a (re)start address: sequential words, mod 2^32.
  task automatic refill(input logic [31:0] start);
    logic [31:0] a;
    exp_t        e;
    sb_q.delete();
    a = start;
    for (int i = 0; i < 256; i++) begin
      e.pc    = a;
      e.instr = mem_word(a);
      sb_q.push_back(e);
`ifdef HALT_DECODE_EN
      if (e.instr[31:30] == 2'b11) break;
`endif
      a = a + 32'd4;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    refill(32'h0);
    cyc();
    cyc();
  endtask

  task automatic redirect(input logic [31:0] t);
    br_taken  = 1'b1;
    br_target = t;
    id_ready  = 1'b0;
    refill(t);
  endtask

  task automatic wait_cons(input int n, input int budget, input string name);
    int start;
    int c;
    start = n_cons;
    c = 0;
    while ((n_cons - start) < n && c < budget) begin
      cyc();
      c++;
    end
    check(name, {63'h0, ((n_cons - start) >= n)}, 64'h1);
  endtask

  // Instruction memory responder, also checking request stability until ack.
  initial begin
    int          wcnt;
    logic        prev_wait;
    logic [31:0] prev_addr;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    wcnt       = 0;
    prev_wait  = 1'b0;
    prev_addr  = '0;
    forever begin
      cyc();
      if (!rst_n) begin
        imem_ack  = 1'b0;
        wcnt      = pick_lat();
        prev_wait = 1'b0;
      end else begin
        if (prev_wait) begin
          check("req_held_until_ack", {63'h0, imem_req}, 64'h1);
          check("addr_stable_until_ack", {32'h0, imem_addr}, {32'h0, prev_addr});
        end
        if (imem_req && wcnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wcnt       = pick_lat();
          prev_wait  = 1'b0;
        end else begin
          imem_ack = 1'b0;
          if (imem_req) begin
            wcnt--;
            prev_wait = 1'b1;
            prev_addr = imem_addr;
          end else begin
            prev_wait = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: every transfer out is popped from the scoreboard and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && id_valid && id_ready && !br_taken) begin
        n_cons++;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_issue: id_pc=0x%0h issued, none expected", id_pc);
        end else begin
          e = sb_q.pop_front();
          check("id_pc", {32'h0, id_pc}, {32'h0, e.pc});
          check("fields", {28'h0, tipo, op, inm, rd, rn, rm, imm},
                {28'h0, e.instr[31:30], e.instr[29:28], e.instr[27], e.instr[26:23],
                 e.instr[22:19], e.instr[18:15], e.instr[18:0]});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic found;
    int   start;
    br_taken  = 1'b0;
    br_target = '0;
    id_ready  = 1'b0;

    // Reset state
    mem_mode = 0;
    apply_reset();
    check("rst_req",      {63'h0, imem_req}, 64'h0);
    check("rst_valid",    {63'h0, id_valid}, 64'h0);
    check("rst_addr",     {32'h0, imem_addr}, 64'h0);
    check("rst_id_pc",    {32'h0, id_pc}, 64'h0);
    check("rst_fields",   {28'h0, tipo, op, inm, rd, rn, rm, imm}, 64'h0);

    // Back-to-back fetch: addresses 0,4,8,C and id_pc one cycle behind
    id_ready = 1'b1;
    rst_n    = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      check("seq_req",  {63'h0, imem_req}, 64'h1);
      check("seq_addr", {32'h0, imem_addr}, 64'(4 * (k - 1)));
      if (k >= 2) begin
        check("seq_valid", {63'h0, id_valid}, 64'h1);
        check("seq_id_pc", {32'h0, id_pc}, 64'(4 * (k - 2)));
      end
      if (k == 2)
        check("decode_4A800005", {28'h0, tipo, op, inm, rd, rn, rm, imm},
              {28'h0, 2'b01, 2'b00, 1'b1, 4'd5, 4'd0, 4'd0, 19'd5});
    end

    // Stall: second word parks in the pending buffer, req drops
    apply_reset();
    id_ready = 1'b1;
    rst_n    = 1'b1;
    cyc();
    cyc();
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("stall_req",   {63'h0, imem_req}, 64'h0);
      check("stall_valid", {63'h0, id_valid}, 64'h1);
      check("stall_id_pc", {32'h0, id_pc}, 64'h0);
      check("stall_imm",   {45'h0, imm}, 64'd5);
    end
    id_ready = 1'b1;
    cyc();
    check("unstall_id_pc", {32'h0, id_pc}, 64'h4);
    check("unstall_valid", {63'h0, id_valid}, 64'h1);
    check("unstall_req",   {63'h0, imem_req}, 64'h1);
    check("unstall_addr",  {32'h0, imem_addr}, 64'h8);
    wait_cons(3, 20, "unstall_flow");

    // Redirect while a 3-cycle fetch is outstanding: DRAIN keeps the address
    mem_mode = 2;
    mem_lat  = 2;
    apply_reset();
    id_ready = 1'b1;
    rst_n    = 1'b1;
    cyc();
    redirect(32'h100);
    for (int k = 0; k < 2; k++) begin
      cyc();
      br_taken = 1'b0;
      id_ready = 1'b1;
      check("drain_req",   {63'h0, imem_req}, 64'h1);
      check("drain_addr",  {32'h0, imem_addr}, 64'h0);
      check("drain_valid", {63'h0, id_valid}, 64'h0);
    end
    cyc();
    check("drain_done_addr",  {32'h0, imem_addr}, 64'h100);
    check("drain_done_valid", {63'h0, id_valid}, 64'h0);
    wait_cons(2, 30, "after_drain_flow");

    // Redirect coinciding with an ack
    mem_mode = 0;
    apply_reset();
    id_ready = 1'b1;
    rst_n    = 1'b1;
    cyc();
    redirect(32'h40);
    cyc();
    br_taken = 1'b0;
    id_ready = 1'b1;
    check("br_ack_addr",  {32'h0, imem_addr}, 64'h40);
    check("br_ack_valid", {63'h0, id_valid}, 64'h0);
    cyc();
    check("br_ack_issue_valid", {63'h0, id_valid}, 64'h1);
    check("br_ack_issue_pc",    {32'h0, id_pc}, 64'h40);

    // PC wrap at the top of the address space
    redirect(32'hFFFF_FFF8);
    cyc();
    br_taken = 1'b0;
    id_ready = 1'b1;
    check("wrap_addr0", {32'h0, imem_addr}, 64'hFFFF_FFF8);
    cyc();
    check("wrap_addr1", {32'h0, imem_addr}, 64'hFFFF_FFFC);
    cyc();
    check("wrap_addr2", {32'h0, imem_addr}, 64'h0);
    wait_cons(3, 20, "wrap_flow");

    // Asynchronous reset in the middle of an outstanding fetch
    mem_mode = 2;
    mem_lat  = 3;
    redirect(32'h300);
    cyc();
    br_taken = 1'b0;
    id_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      @(posedge clk);
      #2;
      if (imem_req && !imem_ack) found = 1'b1;
    end
    check("midwait_reached", {63'h0, found}, 64'h1);
    #1;
    rst_n = 1'b0;
    refill(32'h0);
    mem_mode = 0;
    #1;
    check("async_rst_req",   {63'h0, imem_req}, 64'h0);
    check("async_rst_valid", {63'h0, id_valid}, 64'h0);
    check("async_rst_addr",  {32'h0, imem_addr}, 64'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cyc();
    check("restart_req",  {63'h0, imem_req}, 64'h1);
    check("restart_addr", {32'h0, imem_addr}, 64'h0);
    wait_cons(3, 20, "restart_flow");

    // Word with tipo=2'b11 at 0x200
    redirect(32'h200);
    cyc();
    br_taken = 1'b0;
    id_ready = 1'b1;
`ifdef HALT_DECODE_EN
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cyc();
      if (halted) found = 1'b1;
    end
    check("halt_entered", {63'h0, found}, 64'h1);
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("halt_req",    {63'h0, imem_req}, 64'h0);
      check("halt_flag",   {63'h0, halted}, 64'h1);
    end
    check("halt_valid_after_consume", {63'h0, id_valid}, 64'h0);
    redirect(32'h20);
    cyc();
    br_taken = 1'b0;
    id_ready = 1'b1;
    check("unhalt_flag", {63'h0, halted}, 64'h0);
    check("unhalt_req",  {63'h0, imem_req}, 64'h1);
    check("unhalt_addr", {32'h0, imem_addr}, 64'h20);
    wait_cons(2, 20, "unhalt_flow");
`else
    wait_cons(6, 30, "tipo3_passthrough_flow");
`endif

    // Randomized traffic: random latency, random back-pressure, random redirects
    mem_mode = 1;
    start = n_cons;
    for (int k = 0; k < 3000; k++) begin
      cyc();
      br_taken = 1'b0;
      id_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0)
        redirect(32'h1000 + ({20'h0, 10'($urandom)} << 2));
    end
    check("random_volume", {63'h0, ((n_cons - start) >= 200)}, 64'h1);
    cyc();
    br_taken = 1'b0;
    id_ready = 1'b1;
    wait_cons(4, 100, "final_flow");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
